// File: rtl/if_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch front end.
package if_fetch_pkg;

  localparam logic [31:0] RESET_PC_ADDR = 32'hBFC0_0000;
  localparam int unsigned PC_STEP       = 4;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_HOLD,
    ST_DISCARD
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-ROM request/ready bus between the fetch unit and the ROM.
interface if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ready;
  logic [INST_W-1:0] rom_rdata;

  modport master (output rom_en, rom_addr, input rom_ready, rom_rdata);
  modport slave  (input rom_en, rom_addr, output rom_ready, rom_rdata);
endinterface

// File: rtl/if_fetch_skid_buf.sv
// One-entry {pc, inst} holding slot that catches a fetch returned while decode is stalled.
module fetch_skid_buf #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              full_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o
);

  logic              full_q;
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      inst_q <= '0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (push_i) begin
      full_q <= 1'b1;
      pc_q   <= pc_i;
      inst_q <= inst_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign pc_o   = pc_q;
  assign inst_o = inst_q;

endmodule

// File: rtl/if_fetch.sv
// Fetch front end: owns the PC, talks to the instruction ROM, presents pc/inst to IF/ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  if_fetch_if.master        rom,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              fetch_busy
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_valid_q, pend_valid_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;

  logic              skid_push, skid_pop, skid_full;
  logic [ADDR_W-1:0] skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              ack, take_branch, out_free;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

  // Request dropped combinationally by reset so an abandoned request ends at once.
  assign rom.rom_en   = !rst && (state_q != ST_HOLD);
  assign rom.rom_addr = addr_q;

  assign ack         = rom.rom_en && rom.rom_ready;
  assign take_branch = branch_flag && !stall;
  assign out_free    = !out_valid_q || !stall;

  // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    out_valid_d  = out_valid_q && stall;
    pc_d         = pc_q;
    inst_d       = inst_q;
    skid_push    = 1'b0;
    skid_pop     = 1'b0;

    if (flush) begin
      out_valid_d  = 1'b0;
      pend_valid_d = 1'b0;
      if (state_q == ST_HOLD || ack) begin
        addr_d  = word_align(flush_pc);
        state_d = ST_FETCH;
      end else begin
        // Address must stay put until the ROM answers, so park the target.
        pend_valid_d = 1'b1;
        pend_addr_d  = word_align(flush_pc);
        state_d      = ST_DISCARD;
      end
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (ack) begin
            if (out_free) begin
              out_valid_d = 1'b1;
              pc_d        = addr_q;
              inst_d      = rom.rom_rdata;
            end else begin
              skid_push = 1'b1;
              state_d   = ST_HOLD;
            end
            pend_valid_d = 1'b0;
            if (take_branch)       addr_d = word_align(branch_addr);
            else if (pend_valid_q) addr_d = pend_addr_q;
            else                   addr_d = addr_q + ADDR_W'(PC_STEP);
          end else if (take_branch) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = word_align(branch_addr);
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            out_valid_d = 1'b1;
            pc_d        = skid_pc;
            inst_d      = skid_inst;
            skid_pop    = 1'b1;
            state_d     = ST_FETCH;
            // No request in flight, so a redirect can retarget the address directly.
            if (branch_flag) addr_d = word_align(branch_addr);
          end
        end
        ST_DISCARD: begin
          if (ack) begin
            addr_d       = pend_addr_q;
            pend_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      addr_q       <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      out_valid_q  <= 1'b0;
      pc_q         <= '0;
      inst_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      out_valid_q  <= out_valid_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
    end
  end

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .clear_i (flush),
    .pc_i    (addr_q),
    .inst_i  (rom.rom_rdata),
    .full_o  (skid_full),
    .pc_o    (skid_pc),
    .inst_o  (skid_inst)
  );

  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = out_valid_q;
  assign fetch_busy = rom.rom_en && !rom.rom_ready;

endmodule

// File: tb/tb_if_fetch.sv
// Directed plus randomized bench for if_fetch against a queue-based delivery model.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [31:0] pc, inst;
  logic        inst_valid, fetch_busy;

  if_fetch_if #(.ADDR_W(32), .INST_W(32)) rom ();

  if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branch_flag (branch_flag),
    .branch_addr (branch_addr),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .rom         (rom),
    .pc          (pc),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .fetch_busy  (fetch_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: instructions fetched but not yet taken by decode, oldest first.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_addr;
  logic [31:0] m_pend;
  bit          m_pend_v;
  bit          m_discard;

  function automatic logic [31:0] al(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_addr    = RST_PC;
    m_pend    = '0;
    m_pend_v  = 0;
    m_discard = 0;
  endtask

  // One pipeline cycle: drive inputs, compare against the model, advance the model, clock.
  task automatic step(input logic s, input logic b, input logic [31:0] ba,
                      input logic f, input logic [31:0] fp, input logic r);
    bit exp_en;
    bit ack;
    stall         = s;
    branch_flag   = b;
    branch_addr   = ba;
    flush         = f;
    flush_pc      = fp;
    rom.rom_ready = r;
    rom.rom_rdata = $urandom;
    #1;
    exp_en = m_discard || (mq.size() < 2);
    check("rom_en", rom.rom_en, exp_en);
    check("rom_addr", rom.rom_addr, m_addr);
    check("inst_valid", inst_valid, mq.size() > 0);
    check("fetch_busy", fetch_busy, exp_en && !r);
    if (mq.size() > 0) begin
      check("pc", pc, mq[0].pc);
      check("inst", inst, mq[0].inst);
    end

    ack = exp_en && r;
    if (f) begin
      mq.delete();
      m_pend_v = 0;
      if (ack || !exp_en) begin
        m_addr    = al(fp);
        m_discard = 0;
      end else begin
        m_discard = 1;
        m_pend    = al(fp);
        m_pend_v  = 1;
      end
    end else if (m_discard) begin
      if (ack) begin
        m_addr    = m_pend;
        m_pend_v  = 0;
        m_discard = 0;
      end
    end else begin
      if (!s && mq.size() > 0) void'(mq.pop_front());
      if (ack) begin
        mq.push_back(entry_t'{pc: m_addr, inst: rom.rom_rdata});
        if (b && !s)       m_addr = al(ba);
        else if (m_pend_v) m_addr = m_pend;
        else               m_addr = m_addr + 32'd4;
        m_pend_v = 0;
      end else if (b && !s) begin
        if (exp_en) begin
          m_pend   = al(ba);
          m_pend_v = 1;
        end else begin
          m_addr = al(ba);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go(input logic r);
    step(1'b0, 1'b0, '0, 1'b0, '0, r);
  endtask

  initial begin
    rom.rom_ready = 1'b0;
    rom.rom_rdata = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_rom_en", rom.rom_en, 1'b0);
    check("rst_rom_addr", rom.rom_addr, RST_PC);
    check("rst_pc", pc, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_busy", fetch_busy, 1'b0);
    rst = 1'b0;
    #1;
    check("first_en", rom.rom_en, 1'b1);
    check("first_addr", rom.rom_addr, RST_PC);
    @(negedge clk);

    // Zero-wait start, then three wait states at BFC00004.
    go(1'b1);
    check("seq_addr1", rom.rom_addr, 32'hBFC0_0004);
    check("seq_pc0", pc, 32'hBFC0_0000);
    repeat (3) go(1'b0);
    check("wait_held", rom.rom_addr, 32'hBFC0_0004);
    go(1'b1);
    check("wait_pc", pc, 32'hBFC0_0004);

    // Branch while the delay slot at BFC00008 is outstanding.
    step(1'b0, 1'b1, 32'h8000_0100, 1'b0, '0, 1'b0);
    go(1'b1);
    check("dslot_pc", pc, 32'hBFC0_0008);
    check("br_addr", rom.rom_addr, 32'h8000_0100);
    go(1'b1);
    check("br_pc", pc, 32'h8000_0100);

    // Four stalled cycles: one fetch absorbed, then the request drops.
    repeat (4) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    check("stall_en", rom.rom_en, 1'b0);
    check("stall_pc", pc, 32'h8000_0100);
    go(1'b1);
    check("rel_pc0", pc, 32'h8000_0104);
    go(1'b1);
    check("rel_pc1", pc, 32'h8000_0108);

    // Flush while a request waits: that ack is dropped.
    step(1'b0, 1'b0, '0, 1'b1, 32'hBFC0_0380, 1'b0);
    check("fl_valid", inst_valid, 1'b0);
    go(1'b0);
    go(1'b1);
    check("fl_addr", rom.rom_addr, 32'hBFC0_0380);
    check("fl_valid2", inst_valid, 1'b0);
    go(1'b1);
    check("fl_pc", pc, 32'hBFC0_0380);

    // Flush and branch together with an ack: flush wins.
    step(1'b0, 1'b1, 32'h8000_0100, 1'b1, 32'hBFC0_0380, 1'b1);
    check("flbr_addr", rom.rom_addr, 32'hBFC0_0380);
    check("flbr_valid", inst_valid, 1'b0);
    go(1'b1);
    check("flbr_pc", pc, 32'hBFC0_0380);

    // Address wrap at the top of the space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b1);
    go(1'b1);
    check("wrap_addr", rom.rom_addr, 32'h0000_0000);
    check("wrap_pc", pc, 32'hFFFF_FFFC);

    // Reset in the middle of a wait.
    rom.rom_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_en", rom.rom_en, 1'b0);
    check("mid_rst_addr", rom.rom_addr, RST_PC);
    check("mid_rst_valid", inst_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    go(1'b1);
    check("restart_pc", pc, RST_PC);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
